// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory master.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
//
// Contents: size encodings, FSM state enum, byte-enable constants,
// misalignment test and RAM piece-count function.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DONE  = 2'b10
  } state_e;

  // The only byte-enable patterns the RAM is ever given.
  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_B1   = 4'b0010;
  localparam logic [3:0] BE_B2   = 4'b0100;
  localparam logic [3:0] BE_B3   = 4'b1000;
  localparam logic [3:0] BE_H0   = 4'b0011;
  localparam logic [3:0] BE_H1   = 4'b1100;
  localparam logic [3:0] BE_W    = 4'b1111;

  // Half with odd address, or word not on a 4-byte boundary.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] ofs);
    logic m;
    case (size)
      SZ_HALF: m = ofs[0];
      SZ_WORD: m = (ofs != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  // Number of RAM accesses a request needs. Misaligned stores go out as
  // single bytes; misaligned loads always span exactly two words.
  function automatic logic [2:0] piece_cnt(input logic we, input size_e size,
                                           input logic [1:0] ofs);
    logic [2:0] n;
    if (!is_misaligned(size, ofs)) n = 3'd1;
    else if (!we)                  n = 3'd2;
    else if (size == SZ_WORD)      n = 3'd4;
    else                           n = 3'd2;
    return n;
  endfunction

  function automatic logic [3:0] be_onehot(input logic [1:0] lane);
    logic [3:0] be;
    case (lane)
      2'd0:    be = BE_B0;
      2'd1:    be = BE_B1;
      2'd2:    be = BE_B2;
      default: be = BE_B3;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// CPU request/response and RAM bus bundle for the load/store master.
// Latency: none (wires only).
// Backpressure: req_ready gates the CPU side; mem_ack stalls the RAM side.
//
// modport master: the load/store unit (drives req_ready, resp_*, mem_* outputs).
// modport slave : the environment (CPU + RAM) driving the opposite directions.
interface lsu_mem_master_if #(
  parameter int AW = 8
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_uns;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;

  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout;
  logic          mem_ack;

  modport master (
    input  req_valid, req_we, req_size, req_uns, req_addr, req_wdata,
    input  mem_dout, mem_ack,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_req, mem_we, mem_adr, mem_be, mem_din
  );

  modport slave (
    output req_valid, req_we, req_size, req_uns, req_addr, req_wdata,
    output mem_dout, mem_ack,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_req, mem_we, mem_adr, mem_be, mem_din
  );
endinterface

// File: rtl/lsu_ld_ext.sv
// Load data selection: picks the addressed byte/half/word out of a merged window and extends it.
// Latency: combinational.
// Backpressure: none.
//
// Ports: win  - 64-bit window {hi_word, lo_word} (hi is zero for single-word reads)
//        ofs  - byte offset of the load inside lo_word
//        size - access size; reserved size yields 0
//        uns  - 1 zero-extends, 0 sign-extends
//        data - right-justified extended result
module lsu_ld_ext
  import lsu_pkg::*;
(
  input  logic [63:0] win,
  input  logic [1:0]  ofs,
  input  size_e       size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [31:0] sel;
  logic        unused_win_top;

  // Offset 3 plus four bytes reaches byte 6 at most, so the top byte is dead.
  assign unused_win_top = ^win[63:56];

  always_comb begin
    sel = win[31:0];
    case (ofs)
      2'd0: sel = win[31:0];
      2'd1: sel = win[39:8];
      2'd2: sel = win[47:16];
      2'd3: sel = win[55:24];
      default: sel = win[31:0];
    endcase
  end

  always_comb begin
    data = '0;
    case (size)
      SZ_BYTE: data = {{24{~uns & sel[7]}},  sel[7:0]};
      SZ_HALF: data = {{16{~uns & sel[15]}}, sel[15:0]};
      SZ_WORD: data = sel;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one CPU access in, legal byte-enabled word accesses out to the data RAM.
// Latency: accept -> ISSUE next cycle -> resp_valid one cycle after the last acked piece (2 cycles aligned, ack tied 1).
// Backpressure: req_ready only in IDLE; each piece holds mem_* stable until mem_ack.
//
// Ports: clk - clock; clr - async active-high reset;
//        bus - lsu_mem_master_if.master (req_* in, resp_* out, mem_* to/from the RAM).
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic           clk,
  input  logic           clr,
  lsu_mem_master_if.master bus
);

  state_e        state, state_nx;

  logic          we_q;
  logic          uns_q;
  logic          err_q;
  size_e         size_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   lo_q;
  logic [31:0]   rdata_q;
  logic [1:0]    piece;

  logic          mis;
  logic [2:0]    n_pieces;
  logic          last;
  logic          issuing;
  logic [AW+1:0] byte_pc;
  logic [AW-1:0] word_ld;
  logic [7:0]    wbyte;
  logic [3:0]    be_c;
  logic [31:0]   din_c;
  logic [63:0]   win;
  logic [31:0]   ld_data;
  logic          unused_addr_hi;

  // Only bits [AW+1:0] of the byte address reach the RAM.
  assign unused_addr_hi = ^bus.req_addr[31:AW+2];

  assign mis      = is_misaligned(size_q, addr_q[1:0]);
  assign n_pieces = piece_cnt(we_q, size_q, addr_q[1:0]);
  assign last     = ({1'b0, piece} == (n_pieces - 3'd1));
  assign issuing  = (state == ISSUE);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.req_valid)
          state_nx = (size_e'(bus.req_size) == SZ_RSVD) ? DONE : ISSUE;
      end
      ISSUE: begin
        if (bus.mem_ack && last) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ------------------------------------------------------ request latch
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
      piece   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            uns_q   <= bus.req_uns;
            size_q  <= size_e'(bus.req_size);
            addr_q  <= bus.req_addr[AW+1:0];
            wdata_q <= bus.req_wdata;
            err_q   <= (size_e'(bus.req_size) == SZ_RSVD);
            lo_q    <= '0;
            rdata_q <= '0;
            piece   <= '0;
          end
        end
        ISSUE: begin
          if (bus.mem_ack) begin
            // First read of a split load is the low word of the merge window.
            if (!we_q && (piece == 2'd0)) lo_q <= bus.mem_dout;
            if (!last)      piece   <= piece + 2'd1;
            else if (!we_q) rdata_q <= ld_data;
          end
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------- address generation
  // Split stores walk byte addresses, so the word index follows the carry
  // out of the byte offset. Split loads simply step to the next word.
  // Both wrap naturally at the top of the AW-bit word space.
  assign byte_pc = addr_q + {{AW{1'b0}}, piece};
  assign word_ld = addr_q[AW+1:2] + {{(AW-2){1'b0}}, piece};

  always_comb begin
    wbyte = wdata_q[7:0];
    case (piece)
      2'd0: wbyte = wdata_q[7:0];
      2'd1: wbyte = wdata_q[15:8];
      2'd2: wbyte = wdata_q[23:16];
      2'd3: wbyte = wdata_q[31:24];
      default: wbyte = wdata_q[7:0];
    endcase
  end

  always_comb begin
    be_c  = BE_NONE;
    din_c = '0;
    if (we_q) begin
      if (mis) begin
        be_c  = be_onehot(byte_pc[1:0]);
        din_c = {24'h0, wbyte};
      end else begin
        case (size_q)
          SZ_BYTE: be_c = be_onehot(addr_q[1:0]);
          SZ_HALF: be_c = addr_q[1] ? BE_H1 : BE_H0;
          default: be_c = BE_W;
        endcase
        din_c = wdata_q;
      end
    end
  end

  // ------------------------------------------------------- load merging
  assign win = mis ? {bus.mem_dout, lo_q} : {32'h0, bus.mem_dout};

  lsu_ld_ext u_ld_ext (
    .win  (win),
    .ofs  (addr_q[1:0]),
    .size (size_q),
    .uns  (uns_q),
    .data (ld_data)
  );

  // ------------------------------------------------------------ outputs
  // All mem_* derive from state only, so an async clear drops mem_req at once.
  assign bus.req_ready  = (state == IDLE);
  assign bus.mem_req    = issuing;
  assign bus.mem_we     = issuing & we_q;
  assign bus.mem_adr    = issuing ? (we_q ? byte_pc[AW+1:2] : word_ld) : '0;
  assign bus.mem_be     = issuing ? be_c  : BE_NONE;
  assign bus.mem_din    = issuing ? din_c : '0;
  assign bus.resp_valid = (state == DONE);
  assign bus.resp_rdata = (state == DONE) ? rdata_q : '0;
  assign bus.resp_err   = (state == DONE) & err_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: byte-level memory model, access log and random ack stalls.
module tb_lsu_mem_master;

  localparam int AW = 8;

  logic clk = 1'b0;
  logic clr;

  lsu_mem_master_if #(.AW(AW)) bif ();

  lsu_mem_master #(.AW(AW)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [7:0]  adr;
    logic [3:0]  be;
    logic [31:0] din;
  } acc_t;

  int   total = 0;
  int   bad   = 0;
  logic [31:0] mem [256];
  logic [7:0]  ref_b [1024];
  acc_t log_q [$];
  acc_t mon_cur;
  acc_t prev;
  bit   prev_pend = 1'b0;
  int   stall_left = 0;
  bit   rand_ack = 1'b0;

  assign bif.mem_dout = mem[bif.mem_adr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // RAM + monitor. Everything the RAM sees between two posedges is stable
  // from the preceding negedge, so ack choice, logging and writes happen here.
  always @(negedge clk) begin
    if (bif.mem_req && stall_left > 0) begin
      bif.mem_ack = 1'b0;
      stall_left--;
    end else if (rand_ack) begin
      bif.mem_ack = ($urandom_range(0, 2) != 0);
    end else begin
      bif.mem_ack = 1'b1;
    end
    mon_cur = {bif.mem_we, bif.mem_adr, bif.mem_be, bif.mem_din};
    if (prev_pend) begin
      chk("hold_req", bif.mem_req, 1);
      chk("hold_pins", mon_cur, prev);
    end
    if (bif.mem_req && bif.mem_ack) begin
      log_q.push_back(mon_cur);
      if (bif.mem_we) begin
        chk("be_legal", bif.mem_be inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF}, 1);
        for (int k = 0; k < 4; k++) begin
          if (bif.mem_be[k]) begin
            int src;
            if (bif.mem_be == 4'hF || bif.mem_be == 4'h3) src = k;
            else if (bif.mem_be == 4'hC)                  src = k - 2;
            else                                           src = 0;
            mem[bif.mem_adr][8*k +: 8] = bif.mem_din[8*src +: 8];
          end
        end
      end
    end
    prev_pend = bif.mem_req && !bif.mem_ack && !clr;
    prev      = mon_cur;
  end

  // ------------------------------------------------ reference model
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                           input logic uns);
    logic [31:0] v = '0;
    int n = nbytes(sz);
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_b[(a + i) & 32'h3FF];
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic set_word(input int w, input logic [31:0] v);
    mem[w] = v;
    for (int i = 0; i < 4; i++) ref_b[4*w + i] = v[8*i +: 8];
  endtask

  task automatic do_op(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int exp_lat, input bit poke, output logic [31:0] rd);
    acc_t        exp_q [$];
    logic [31:0] exp_rd;
    logic [9:0]  ba;
    bit          misal;
    int          n;
    int          lat;
    bit          got;
    rd    = '0;
    n     = nbytes(sz);
    misal = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    if (sz != 2'd3) begin
      if (we && misal) begin
        for (int i = 0; i < n; i++) begin
          ba = 10'((a + i) & 32'h3FF);
          exp_q.push_back({1'b1, ba[9:2], 4'(1 << ba[1:0]), {24'h0, wd[8*i +: 8]}});
        end
      end else if (we) begin
        exp_q.push_back({1'b1, a[9:2],
                         (sz == 2'd0) ? 4'(1 << a[1:0]) : (sz == 2'd1) ? (a[1] ? 4'hC : 4'h3) : 4'hF,
                         wd});
      end else begin
        exp_q.push_back({1'b0, a[9:2], 4'h0, 32'h0});
        if (misal) exp_q.push_back({1'b0, 8'(a[9:2] + 8'd1), 4'h0, 32'h0});
      end
    end
    exp_rd = (sz == 2'd3 || we) ? 32'h0 : ref_load(a, sz, uns);
    if (we && sz != 2'd3)
      for (int i = 0; i < n; i++) ref_b[(a + i) & 32'h3FF] = wd[8*i +: 8];

    @(negedge clk);
    chk("ready_idle", bif.req_ready, 1);
    bif.req_we    = we;
    bif.req_size  = sz;
    bif.req_uns   = uns;
    bif.req_addr  = a;
    bif.req_wdata = wd;
    bif.req_valid = 1'b1;
    log_q.delete();
    @(posedge clk);
    #1;
    bif.req_valid = 1'b0;
    bif.req_we    = 1'($urandom);
    bif.req_size  = 2'($urandom);
    bif.req_addr  = $urandom;
    bif.req_wdata = $urandom;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (bif.resp_valid) begin
        got = 1'b1;
        rd  = bif.resp_rdata;
        chk("resp_rdata", bif.resp_rdata, exp_rd);
        chk("resp_err", bif.resp_err, sz == 2'd3);
        bif.req_valid = 1'b0;
      end else begin
        chk("busy_ready", bif.req_ready, 0);
        if (poke) begin
          bif.req_valid = 1'($urandom);
          bif.req_addr  = $urandom;
          bif.req_size  = 2'($urandom);
        end
      end
    end
    chk("resp_seen", got, 1);
    if (exp_lat >= 0) chk("latency", lat, exp_lat);
    chk("n_access", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      if (exp_q[i].we) chk("access_wr", log_q[i], exp_q[i]);
      else             chk("access_rd", {log_q[i].we, log_q[i].adr, log_q[i].be},
                                        {exp_q[i].we, exp_q[i].adr, exp_q[i].be});
    end
    @(negedge clk);
    chk("resp_pulse", bif.resp_valid, 0);
  endtask

  // ---------------------------------------------------------- stimulus
  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [1:0]  sz;

    clr           = 1'b1;
    bif.req_valid = 1'b0;
    bif.req_we    = 1'b0;
    bif.req_size  = 2'b00;
    bif.req_uns   = 1'b0;
    bif.req_addr  = '0;
    bif.req_wdata = '0;
    for (int w = 0; w < 256; w++) set_word(w, $urandom);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", bif.req_ready, 1);
    chk("rst_resp_valid", bif.resp_valid, 0);
    chk("rst_resp", {bif.resp_rdata, bif.resp_err}, 0);
    chk("rst_mem", {bif.mem_req, bif.mem_we, bif.mem_adr, bif.mem_be, bif.mem_din}, 0);
    clr = 1'b0;

    // Aligned store
    do_op(1'b1, 2'd2, 1'b0, 32'h010, 32'hDEAD_BEEF, 2, 1'b0, rd);
    chk("sw_word4", mem[4], 32'hDEAD_BEEF);

    // Byte loads, signed and unsigned
    set_word(4, 32'h80FF_0000);
    do_op(1'b0, 2'd0, 1'b0, 32'h013, 32'h0, 2, 1'b0, rd);
    chk("lb", rd, 32'hFFFF_FF80);
    do_op(1'b0, 2'd0, 1'b1, 32'h013, 32'h0, 2, 1'b0, rd);
    chk("lbu", rd, 32'h0000_0080);

    // Misaligned word load
    set_word(4, 32'h4433_2211);
    set_word(5, 32'h8877_6655);
    do_op(1'b0, 2'd2, 1'b0, 32'h011, 32'h0, 3, 1'b0, rd);
    chk("lw_mis", rd, 32'h5544_3322);
    do_op(1'b0, 2'd1, 1'b0, 32'h013, 32'h0, 3, 1'b0, rd);
    chk("lh_mis", rd, 32'h0000_5544);

    // Misaligned half store
    do_op(1'b1, 2'd1, 1'b0, 32'h00B, 32'h0000_ABCD, 3, 1'b0, rd);
    chk("sh_mis_lo", mem[2][31:24], 8'hCD);
    chk("sh_mis_hi", mem[3][7:0], 8'hAB);

    // Wait states with busy pokes, then reserved size
    stall_left = 3;
    do_op(1'b1, 2'd2, 1'b0, 32'h020, 32'h1234_5678, 5, 1'b1, rd);
    stall_left = 3;
    do_op(1'b0, 2'd2, 1'b1, 32'h022, 32'h0, 6, 1'b1, rd);
    do_op(1'b0, 2'd3, 1'b0, 32'h040, 32'h0, 1, 1'b0, rd);
    do_op(1'b1, 2'd3, 1'b0, 32'h044, 32'hFFFF_FFFF, 1, 1'b1, rd);

    // Reset after the first piece of a split word store
    @(negedge clk);
    bif.req_we    = 1'b1;
    bif.req_size  = 2'd2;
    bif.req_uns   = 1'b0;
    bif.req_addr  = 32'h005;
    bif.req_wdata = 32'hCAFE_F00D;
    bif.req_valid = 1'b1;
    log_q.delete();
    @(posedge clk);
    #1;
    bif.req_valid = 1'b0;
    @(posedge clk);
    #1;
    clr = 1'b1;
    #1;
    chk("clr_mem_req", bif.mem_req, 0);
    chk("clr_resp", bif.resp_valid, 0);
    ref_b[5] = 8'h0D;
    @(negedge clk);
    chk("clr_pieces", log_q.size(), 1);
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("clr_no_resp", bif.resp_valid, 0);
    end

    // Word-address wrap on a split load
    do_op(1'b0, 2'd2, 1'b0, 32'h3FD, 32'h0, 3, 1'b0, rd);
    if (log_q.size() == 2) begin
      chk("wrap_adr0", log_q[0].adr, 8'hFF);
      chk("wrap_adr1", log_q[1].adr, 8'h00);
    end
    do_op(1'b1, 2'd2, 1'b0, 32'h3FE, 32'h0BAD_F00D, 5, 1'b0, rd);

    // Random traffic with random ack stalls
    rand_ack = 1'b1;
    for (int t = 0; t < 200; t++) begin
      a  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 63)) : 32'($urandom_range(1000, 1023));
      a  = a | ($urandom << 10);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      do_op(1'($urandom), sz, 1'($urandom), a, $urandom, -1, 1'($urandom), rd);
    end
    rand_ack = 1'b0;

    // Final memory image against the byte model
    for (int w = 0; w < 256; w++)
      chk("mem_image", mem[w], {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute bound so a wedged run still reports.
  initial begin
    #400000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
